// File: rtl/mono_pkg.sv
// Shared constants for the monochrome mode controller: output modes,
// PS/2 set-2 prefix codes and the scan-code decoder state encoding.
package mono_pkg;

    localparam logic [1:0] MONO_COLOUR = 2'd0;
    localparam logic [1:0] MONO_GREEN  = 2'd1;
    localparam logic [1:0] MONO_AMBER  = 2'd2;
    localparam logic [1:0] MONO_WHITE  = 2'd3;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } dec_state_t;

    // Hotkey steps through the four modes, wrapping white back to colour.
    function automatic logic [1:0] mode_next(input logic [1:0] mode);
        return mode + 2'd1;
    endfunction

endpackage

// File: rtl/mono_mode_ctrl_if.sv
// CPU I/O port bundle for the mode controller: write strobe, write data
// and the status readback.
interface mono_mode_ctrl_if;
    logic       io_we;
    logic [7:0] io_din;
    logic [7:0] io_dout;

    modport master (output io_we, output io_din, input  io_dout);
    modport slave  (input  io_we, input  io_din, output io_dout);
endinterface

// File: rtl/ps2_sniff_rx.sv
// Passive PS/2 frame receiver: synchronises the keyboard lines, samples on
// clock falling edges and emits one-cycle byte_valid for good frames only.
module ps2_sniff_rx #(
    parameter int TIMEOUT_CYCLES = 2864
) (
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_hist;
    logic          clk_fall;
    logic          bit_in;

    logic          busy;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_acc;
    logic [TW-1:0] tmr;

    // Idle-high reset values keep a reset from looking like a clock edge.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_hist <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
            clk_hist <= clk_sync[1];
        end
    end

    assign clk_fall = clk_hist & ~clk_sync[1];
    assign bit_in   = dat_sync[1];

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            par_acc    <= 1'b0;
            tmr        <= TO_LOAD;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            byte_valid <= 1'b0;
            if (clk_fall) begin
                tmr <= TO_LOAD;
                if (!busy) begin
                    if (!bit_in) begin
                        busy    <= 1'b1;
                        bit_cnt <= 4'd1;
                        par_acc <= 1'b0;
                    end
                end else if (bit_cnt <= 4'd8) begin
                    shift   <= {bit_in, shift[7:1]};
                    par_acc <= par_acc ^ bit_in;
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par_acc <= par_acc ^ bit_in;
                    bit_cnt <= bit_cnt + 4'd1;
                end else begin
                    // Stop bit: odd parity over data+parity and a high stop.
                    busy <= 1'b0;
                    if (par_acc && bit_in) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift;
                    end
                end
            end else if (busy) begin
                if (tmr == '0) begin
                    busy <= 1'b0;
                end else begin
                    tmr <= tmr - TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mono_mode_ctrl.sv
// Monochrome mode register: CPU writes or a PS/2 hotkey set a pending mode,
// committed at the active vsync edge. Hotkey path is built only with MONO_HOTKEY_EN.
//
// Decoder states:
//   state    | meaning
//   IDLE     | no prefix seen; hotkey code here is a make
//   GOT_E0   | extended prefix seen
//   GOT_F0   | break prefix seen; hotkey code here is a break
//   GOT_E0F0 | extended break prefix seen; next byte never matches
module mono_mode_ctrl
    import mono_pkg::*;
#(
    parameter int       TIMEOUT_CYCLES   = 2864,
    parameter bit [7:0] HOTKEY_CODE      = 8'h07,
    parameter bit       VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk_vga,
    input  logic               rst_n,
    input  logic               ps2_clk_in,
    input  logic               ps2_data_in,
    input  logic               vga_vsync,
    mono_mode_ctrl_if.slave    io,
    output logic [1:0]         monochrome_switcher
);

    localparam logic VS_IDLE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0] pending;
    logic [1:0] current;
    logic [1:0] vs_sync;
    logic       vs_hist;
    logic       vs_edge;
    logic       hk_fire;
    logic       unused_din;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync <= {2{VS_IDLE}};
            vs_hist <= VS_IDLE;
        end else begin
            vs_sync <= {vs_sync[0], vga_vsync};
            vs_hist <= vs_sync[1];
        end
    end

    assign vs_edge = (vs_sync[1] != VS_IDLE) && (vs_hist == VS_IDLE);

`ifdef MONO_HOTKEY_EN
    logic       byte_valid;
    logic [7:0] byte_data;
    dec_state_t dec_state;
    dec_state_t dec_next;
    logic       hk_make;
    logic       hk_break;
    logic       armed;

    ps2_sniff_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_vga     (clk_vga),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data)
    );

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            dec_state <= IDLE;
            armed     <= 1'b1;
        end else begin
            dec_state <= dec_next;
            if (hk_break) begin
                armed <= 1'b1;
            end else if (hk_fire) begin
                armed <= 1'b0;
            end
        end
    end

    always_comb begin
        dec_next = dec_state;
        hk_make  = 1'b0;
        hk_break = 1'b0;
        if (byte_valid) begin
            dec_next = IDLE;
            case (dec_state)
                IDLE: begin
                    if (byte_data == SC_E0) begin
                        dec_next = GOT_E0;
                    end else if (byte_data == SC_F0) begin
                        dec_next = GOT_F0;
                    end else if (byte_data == HOTKEY_CODE) begin
                        hk_make = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (byte_data == SC_F0) begin
                        dec_next = GOT_E0F0;
                    end
                end
                GOT_F0: begin
                    if (byte_data == HOTKEY_CODE) begin
                        hk_break = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Only the first make after a break counts, so typematic repeats are inert.
    assign hk_fire = hk_make & armed;
`else
    logic unused_ps2;
    assign unused_ps2 = ^{ps2_clk_in, ps2_data_in, HOTKEY_CODE, TIMEOUT_CYCLES[0]};
    assign hk_fire    = 1'b0;
`endif

    // A CPU write in the same cycle as a hotkey event wins outright.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            pending <= MONO_COLOUR;
            current <= MONO_COLOUR;
        end else begin
            if (io.io_we) begin
                pending <= io.io_din[1:0];
            end else if (hk_fire) begin
                pending <= mode_next(pending);
            end
            if (vs_edge) begin
                current <= pending;
            end
        end
    end

    assign unused_din          = ^io.io_din[7:2];
    assign io.io_dout          = {4'b0000, current, pending};
    assign monochrome_switcher = current;

endmodule

// File: tb/tb_mono_mode_ctrl.sv
// Directed bench for mono_mode_ctrl: stimulus queues expected status/output
// pairs, a monitor process pops and compares them at the due cycle.
module tb_mono_mode_ctrl;
    import mono_pkg::*;

    logic       clk_vga     = 1'b0;
    logic       rst_n       = 1'b0;
    logic       ps2_clk_in  = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic       vga_vsync   = 1'b1;
    logic [1:0] mono;

    mono_mode_ctrl_if io_bus ();

    mono_mode_ctrl #(
        .TIMEOUT_CYCLES   (2864),
        .HOTKEY_CODE      (8'h07),
        .VSYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_vga             (clk_vga),
        .rst_n               (rst_n),
        .ps2_clk_in          (ps2_clk_in),
        .ps2_data_in         (ps2_data_in),
        .vga_vsync           (vga_vsync),
        .io                  (io_bus),
        .monochrome_switcher (mono)
    );

    always #5 clk_vga = ~clk_vga;

    int cyc = 0;
    always @(posedge clk_vga) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [7:0] dout;
        logic [1:0] mono;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_vga);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (io_bus.io_dout !== e.dout || mono !== e.mono) begin
                    n_err++;
                    $display("FAIL %s: got dout=%h mono=%0d, expected dout=%h mono=%0d",
                             e.name, io_bus.io_dout, mono, e.dout, e.mono);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] d, input logic [1:0] m);
        exp_t e;
        e.name = name;
        e.dout = d;
        e.mono = m;
        e.due  = cyc + 1;
        sb.push_back(e);
        repeat (2) @(negedge clk_vga);
    endtask

    task automatic cpu_write(input logic [7:0] d);
        @(negedge clk_vga);
        io_bus.io_we  = 1'b1;
        io_bus.io_din = d;
        @(negedge clk_vga);
        io_bus.io_we  = 1'b0;
        io_bus.io_din = 8'h00;
    endtask

    task automatic vsync_pulse();
        @(negedge clk_vga);
        vga_vsync = 1'b0;
        repeat (6) @(negedge clk_vga);
        vga_vsync = 1'b1;
        repeat (4) @(negedge clk_vga);
    endtask

    // Write lands on the same edge that commits pending to current.
    task automatic vsync_with_write(input logic [7:0] d);
        @(negedge clk_vga);
        vga_vsync = 1'b0;
        repeat (2) @(negedge clk_vga);
        io_bus.io_we  = 1'b1;
        io_bus.io_din = d;
        @(negedge clk_vga);
        io_bus.io_we  = 1'b0;
        io_bus.io_din = 8'h00;
        repeat (4) @(negedge clk_vga);
        vga_vsync = 1'b1;
        repeat (4) @(negedge clk_vga);
    endtask

    // With we_stop set, io_we (data 3) coincides with the hotkey event cycle.
    task automatic send_bit(input logic b, input bit we_stop);
        @(negedge clk_vga);
        ps2_data_in = b;
        repeat (3) @(negedge clk_vga);
        ps2_clk_in = 1'b0;
        if (we_stop) begin
            repeat (3) @(negedge clk_vga);
            io_bus.io_we  = 1'b1;
            io_bus.io_din = 8'h03;
            @(negedge clk_vga);
            io_bus.io_we  = 1'b0;
            io_bus.io_din = 8'h00;
            repeat (4) @(negedge clk_vga);
        end else begin
            repeat (8) @(negedge clk_vga);
        end
        ps2_clk_in = 1'b1;
        repeat (4) @(negedge clk_vga);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par = 1'b0,
                              input bit we_stop = 1'b0, input int nbits = 11);
        logic [10:0] f;
        logic        p;
        p = ~(^d) ^ bad_par;
        f = {1'b1, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(f[i], we_stop && (i == 10));
        end
        ps2_data_in = 1'b1;
    endtask

    logic [7:0] mk_dout [4] = '{8'h01, 8'h06, 8'h0B, 8'h0C};
    logic [7:0] cm_dout [4] = '{8'h05, 8'h0A, 8'h0F, 8'h00};
    logic [1:0] mk_mono [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] cm_mono [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        io_bus.io_we  = 1'b0;
        io_bus.io_din = 8'h00;
        repeat (3) @(negedge clk_vga);
        chk("reset", 8'h00, MONO_COLOUR);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_vga);

        cpu_write(8'h02);
        chk("wr_pend", 8'h02, MONO_COLOUR);
        vsync_pulse();
        chk("commit", 8'h0A, MONO_AMBER);
        if (io_bus.io_dout !== 8'h0A || mono !== MONO_AMBER) begin
            n_err++;
            $display("FAIL commit_direct: got dout=%h mono=%0d", io_bus.io_dout, mono);
        end

        cpu_write(8'h00);
        chk("wr_zero", 8'h08, MONO_AMBER);
        vsync_pulse();
        chk("commit_zero", 8'h00, MONO_COLOUR);

        cpu_write(8'h03);
        cpu_write(8'h01);
        chk("wr_last", 8'h01, MONO_COLOUR);
        vsync_pulse();
        chk("commit_last", 8'h05, MONO_GREEN);

        cpu_write(8'hFE);
        chk("wr_upper_bits", 8'h06, MONO_GREEN);
        vsync_with_write(8'h03);
        chk("vs_same_cycle", 8'h0B, MONO_AMBER);
        vsync_pulse();
        chk("vs_next_frame", 8'h0F, MONO_WHITE);

`ifndef MONO_HOTKEY_EN
        send_frame(8'h07);
        chk("ps2_ignored", 8'h0F, MONO_WHITE);
`endif
        cpu_write(8'h00);
        vsync_pulse();
        chk("clear", 8'h00, MONO_COLOUR);
        if (io_bus.io_dout !== 8'h00 || mono !== MONO_COLOUR) begin
            n_err++;
            $display("FAIL clear_direct: got dout=%h mono=%0d", io_bus.io_dout, mono);
        end

`ifdef MONO_HOTKEY_EN
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h07);
            chk("hk_make", mk_dout[i], mk_mono[i]);
            send_frame(8'hF0);
            send_frame(8'h07);
            vsync_pulse();
            chk("hk_commit", cm_dout[i], cm_mono[i]);
        end

        send_frame(8'h07);
        send_frame(8'h07);
        send_frame(8'h07);
        chk("repeat", 8'h01, MONO_COLOUR);
        send_frame(8'hF0);
        send_frame(8'h07);
        vsync_pulse();
        chk("repeat_commit", 8'h05, MONO_GREEN);

        cpu_write(8'h00);
        vsync_pulse();
        chk("clear2", 8'h00, MONO_COLOUR);

        send_frame(8'h07, 1'b1);
        chk("bad_parity", 8'h00, MONO_COLOUR);
        send_frame(8'h07, 1'b0, 1'b0, 5);
        repeat (3000) @(negedge clk_vga);
        chk("timeout_partial", 8'h00, MONO_COLOUR);
        send_frame(8'h07);
        chk("after_timeout", 8'h01, MONO_COLOUR);
        send_frame(8'hF0);
        send_frame(8'h07);

        send_frame(8'hE0);
        send_frame(8'h07);
        chk("ext_make", 8'h01, MONO_COLOUR);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h07);
        chk("ext_break", 8'h01, MONO_COLOUR);
        send_frame(8'h07);
        chk("idle_again", 8'h02, MONO_COLOUR);
        send_frame(8'hF0);
        send_frame(8'h07);

        send_frame(8'h07, 1'b0, 1'b1);
        chk("write_beats_hk", 8'h03, MONO_COLOUR);
        send_frame(8'hF0);
        send_frame(8'h07);
`endif

        cpu_write(8'h02);
        vsync_pulse();
        chk("pre_reset", 8'h0A, MONO_AMBER);
        send_frame(8'h07, 1'b0, 1'b0, 4);
        @(negedge clk_vga);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_vga);
        rst_n = 1'b1;
        chk("reset_mid_frame", 8'h00, MONO_COLOUR);
        if (io_bus.io_dout !== 8'h00 || mono !== MONO_COLOUR) begin
            n_err++;
            $display("FAIL reset_mid_frame_direct: got dout=%h mono=%0d", io_bus.io_dout, mono);
        end
`ifdef MONO_HOTKEY_EN
        send_frame(8'h07);
        chk("after_reset_hk", 8'h01, MONO_COLOUR);
`endif

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk_vga);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_err++;
            $display("FAIL %s: never compared, expected dout=%h mono=%0d", e.name, e.dout, e.mono);
        end
        if (n_checks < 12) begin
            n_err++;
            $display("FAIL too few checks: %0d", n_checks);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mono_mode_ctrl.md
# mono_mode_ctrl

Sets the `monochrome_switcher` mode consumed by the video output colour/monochrome converter. The mode can be set by a CPU I/O-port write, or cycled by a keyboard hotkey that the block detects by passively listening to the PS/2 keyboard lines. A requested mode is held as pending and is committed to the output only at the start of vertical sync, so a change never tears a frame. The block sits in `system_512KB`, next to the keyboard and VGA logic, in the `clk_vga` domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 2864: idle `clk_vga` cycles (about 100 µs at 28.636 MHz) after which a partial PS/2 frame is discarded.
- `HOTKEY_CODE`, 8'h07: set-2 make code of the hotkey (F12).
- `VSYNC_ACTIVE_LOW`, 1: polarity of `vga_vsync`.

Ports:
- `clk_vga`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ps2_clk_in`, in, 1: keyboard PS/2 clock, sampled only, never driven.
- `ps2_data_in`, in, 1: keyboard PS/2 data, sampled only.
- `vga_vsync`, in, 1: VGA vertical sync.
- `io_we`, in, 1: one-cycle write strobe for this block's port (address decode is done outside).
- `io_din`, in, 8: write data; only [1:0] is used.
- `io_dout`, out, 8: status, `{4'b0, current[1:0], pending[1:0]}`.
- `monochrome_switcher`, out, 2: committed mode. 0 = colour, 1 = green, 2 = amber, 3 = white.

## Operation
- Registers: `pending[1:0]` and `current[1:0]`. `monochrome_switcher` equals `current`.
- **CPU write.** `io_we` sets `pending` to `io_din[1:0]` on the next edge.
- **Hotkey.** A qualifying hotkey make sets `pending` to `pending + 1`, modulo 4 (3 wraps to 0).
- **Write and hotkey in the same cycle.** The CPU write wins and the hotkey event is dropped.
- **Commit.** On the active edge of the synchronised vsync, `current` takes the value of `pending`.
- **Vsync and pending update in the same cycle.** The commit uses the old `pending`. The new value commits on the next frame.
- **PS/2 sampling.** Each line passes through a 2-flop synchroniser plus one history flop. A falling edge of the PS/2 clock samples one bit.
- **PS/2 frame.** 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- **Frame rejection.** Bad start, parity or stop bits drop the frame silently and return the receiver to idle.
- **Timeout.** The timeout counter reloads on every PS/2 clock falling edge. If it reaches `TIMEOUT_CYCLES` mid-frame, the receiver returns to idle.
- **Decoder FSM**, states `IDLE`, `GOT_E0`, `GOT_F0`, `GOT_E0F0`:
  - Byte E0: `IDLE` → `GOT_E0`.
  - Byte F0: `IDLE` → `GOT_F0`; `GOT_E0` → `GOT_E0F0`.
  - Any other byte returns to `IDLE` after it is classified.
  - `HOTKEY_CODE` received in `IDLE` is a hotkey make.
  - `HOTKEY_CODE` received in `GOT_F0` is a hotkey break.
  - Extended (E0-prefixed) codes never match the hotkey.
- **Auto-repeat suppression.** An `armed` flag (reset value 1) gates hotkey makes.
  - A hotkey make with `armed` = 1 fires the hotkey event and clears `armed`.
  - A hotkey break sets `armed`.
  - Typematic repeats therefore do not cycle the mode.

## Timing
- **Reset values:** `pending` = 0, `current` = 0, `monochrome_switcher` = 0, `io_dout` = 0, `armed` = 1, receiver and decoder in `IDLE`.
- **Reset mid-frame:** the partial frame is abandoned.
- **CPU write to `io_dout`:** `pending` is visible in `io_dout` one cycle after `io_we`.
- **Hotkey to `pending`:** `pending` updates 1 cycle after the stop bit is sampled.
- **PS/2 clock to decode:** 3 cycles of synchroniser/edge-detect latency.
- **Vsync to output:** the active vsync edge reaches `monochrome_switcher` in 3 cycles (2 sync flops plus edge register).
- The output changes only in the cycle that `current` is written.

## Configuration
- `MONO_HOTKEY_EN` defined: the PS/2 listener, decoder and `armed` logic are built.
- `MONO_HOTKEY_EN` undefined:
  - Only the CPU write path and vsync commit remain.
  - `ps2_clk_in` and `ps2_data_in` are ignored.
  - `TIMEOUT_CYCLES` and `HOTKEY_CODE` have no effect.

## Structure
- Shared package `mono_pkg` holds:
  - the mode constants `MONO_COLOUR`, `MONO_GREEN`, `MONO_AMBER`, `MONO_WHITE`;
  - the scan-code constants `SC_E0` and `SC_F0`;
  - the decoder state encoding.
- One sub-module, `ps2_sniff_rx`:
  - contains the synchroniser, edge detect, bit counter, shift register, parity check and timeout;
  - outputs a one-cycle `byte_valid` with `byte_data[7:0]`.

## Test plan
- **CPU write commits at vsync.** Reset, then write `io_din` = 8'h02.
  - `io_dout` reads 8'h02 and the output stays 0.
  - After an active vsync edge plus 3 cycles, the output is 2 and `io_dout` reads 8'h0A.
- **Hotkey cycles with wrap.** Send 07, F0 07 four times, with a vsync after each.
  - The output steps 1, 2, 3, 0.
- **Auto-repeat suppressed.** Send 07 07 07, then F0 07, then vsync.
  - The output is 1, not 3.
- **Bad or incomplete frames ignored.** Send byte 07 with wrong parity, then a 5-bit partial frame that stalls for more than `TIMEOUT_CYCLES`, then a valid 07.
  - `pending` is 1 only after the valid frame.
- **Extended code ignored.** Send E0 07, then E0 F0 07.
  - `pending` is unchanged.
- **Simultaneous events.** Assert `io_we` with 8'h03 in the same cycle as a hotkey event.
  - `pending` is 3.
- **Reset mid-frame.** Pulse `rst_n` mid-frame.
  - The output is 0.
  - The next valid 07 yields `pending` = 1.
